dma_write_burst_engine: RTL and testbench

- Downstream consumer of the DMA_WRITE AXI-Lite status/control register block.
- Watches DMA_Trigger for a start command, drains a first-word-fall-through (FWFT) data FIFO, and writes the data to DDR through an AXI4 master write port as INCR bursts.
- Bursts never cross a 4 KB boundary.
- Returns a one-cycle IRQ pulse plus a packed status word; software reads that word back through the register block.

---
 rtl/dma_write_pkg.sv | 29 ++
 rtl/dma_write_burst_engine_len_calc.sv | 33 +++
 rtl/dma_write_burst_engine.sv | 218 +++++++++++++++++++++
 tb/tb_dma_write_burst_engine.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_write_pkg.sv
// Shared types and constants for the DMA write burst engine.
package dma_write_pkg;

    // DONE is encoded as 0 so a finished transfer reads back with a clear state field.
    typedef enum logic [3:0] {
        ST_DONE = 4'd0,
        ST_IDLE = 4'd1,
        ST_ADDR = 4'd2,
        ST_DATA = 4'd3,
        ST_RESP = 4'd4
    } state_e;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_ERR       = 2;
    localparam int STAT_ABORT     = 3;
    localparam int STAT_STATE_LSB = 4;
    localparam int STAT_BEATS_LSB = 16;

    localparam int TRIG_START = 0;
    localparam int TRIG_ABORT = 1;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int unsigned PAGE_BYTES = 4096;

endpackage

// File: rtl/dma_write_burst_engine_len_calc.sv
// Burst length: min(remaining, MAX_BURST, beats left before the next 4 KB page).
module dma_burst_len_calc
    import dma_write_pkg::*;
#(
    parameter int LEN_WIDTH = 16,
    parameter int MAX_BURST = 16
) (
    input  logic [11:2]          addr,
    input  logic [LEN_WIDTH-1:0] remaining,
    output logic [8:0]           blen
);

    localparam int CW = (LEN_WIDTH > 12) ? LEN_WIDTH : 12;

    logic [10:0]   page_beats;
    logic [CW-1:0] rem_x;
    logic [CW-1:0] page_x;
    logic [CW-1:0] max_x;
    logic [CW-1:0] min_x;

    // Word offset 0 yields a full page (1024 beats), later clamped by MAX_BURST.
    always_comb begin
        page_beats = 11'(PAGE_BYTES / 4) - {1'b0, addr};
        rem_x      = CW'(remaining);
        page_x     = CW'(page_beats);
        max_x      = CW'(MAX_BURST);
        min_x      = rem_x;
        if (page_x < min_x) min_x = page_x;
        if (max_x < min_x)  min_x = max_x;
        blen       = 9'(min_x);
    end

endmodule

// File: rtl/dma_write_burst_engine.sv
// Drains an FWFT FIFO into DDR as 4 KB-safe AXI4 INCR write bursts.
//
// state | meaning
// IDLE  | reset state, waiting for a start edge
// ADDR  | check abort, then present AW and hold until AWREADY
// DATA  | stream FIFO words on W, WLAST on the final beat
// RESP  | wait for B, advance address/remaining
// DONE  | status held, a new start edge re-arms
module dma_write_burst_engine
    import dma_write_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [31:0]             DMA_Trigger,
    input  logic [ADDR_WIDTH-1:0]   DMA_BASE_ADDR,
    input  logic [LEN_WIDTH-1:0]    DMA_LEN_BEATS,
    input  logic [DATA_WIDTH-1:0]   FIFO_RDATA,
    input  logic                    FIFO_EMPTY,
    output logic                    FIFO_RDEN,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]              M_AXI_AWLEN,
    output logic [2:0]              M_AXI_AWSIZE,
    output logic [1:0]              M_AXI_AWBURST,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WLAST,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic                    IRQ,
    output logic [31:0]             DMA_STATUS
);

    state_e                state_q, state_d;
    logic                  trig_prev_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;
    logic [7:0]            beat_q, beat_d;
    logic [7:0]            awlen_q, awlen_d;
    logic                  awvalid_q, awvalid_d;
    logic                  irq_q, irq_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  abt_q, abt_d;
    logic [31:0]           status_q, status_d;

    logic [8:0] blen_calc;
    logic [8:0] blen_cur;
    logic       start;
    logic       abort;
    logic       w_valid;
    logic       w_last;
    logic       w_fire;
    logic       unused_inputs;

    assign unused_inputs = ^{DMA_Trigger[31:2], DMA_BASE_ADDR[1:0]};

    assign start    = DMA_Trigger[TRIG_START] & ~trig_prev_q;
    assign abort    = DMA_Trigger[TRIG_ABORT];
    assign w_valid  = (state_q == ST_DATA) & ~FIFO_EMPTY;
    assign w_last   = (state_q == ST_DATA) & (beat_q == awlen_q);
    assign w_fire   = w_valid & M_AXI_WREADY;
    assign blen_cur = {1'b0, awlen_q} + 9'd1;

    dma_burst_len_calc #(
        .LEN_WIDTH (LEN_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) u_len_calc (
        .addr      (addr_q[11:2]),
        .remaining (rem_q),
        .blen      (blen_calc)
    );

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = awlen_q;
    assign M_AXI_AWSIZE  = SIZE_4B;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = FIFO_RDATA;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = w_last;
    assign M_AXI_WVALID  = w_valid;
    assign M_AXI_BREADY  = (state_q == ST_RESP);
    assign FIFO_RDEN     = w_fire;
    assign IRQ           = irq_q;
    assign DMA_STATUS    = status_q;

    // Next-state, counters, AW channel registers and packed status.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        beats_d   = beats_q;
        beat_d    = beat_q;
        awlen_d   = awlen_q;
        awvalid_d = awvalid_q;
        irq_d     = 1'b0;
        done_d    = done_q;
        err_d     = err_q;
        abt_d     = abt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    abt_d   = 1'b0;
                    beats_d = '0;
                    addr_d  = {DMA_BASE_ADDR[ADDR_WIDTH-1:2], 2'b00};
                    rem_d   = DMA_LEN_BEATS;
                    if (DMA_LEN_BEATS == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        irq_d   = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                // Abort is only honoured before AWVALID goes up for the next burst.
                if (!awvalid_q) begin
                    if (abort) begin
                        state_d = ST_DONE;
                        abt_d   = 1'b1;
                        irq_d   = 1'b1;
                    end else begin
                        awvalid_d = 1'b1;
                        awlen_d   = 8'(blen_calc - 9'd1);
                    end
                end else if (M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_fire) begin
                    if (beats_q != '1) beats_d = beats_q + LEN_WIDTH'(1);
                    if (w_last) state_d = ST_RESP;
                    else        beat_d  = beat_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != RESP_OKAY) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                        irq_d   = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'({blen_cur, 2'b00});
                        rem_d  = rem_q - LEN_WIDTH'(blen_cur);
                        if (rem_d == '0) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                            irq_d   = 1'b1;
                        end else begin
                            state_d = ST_ADDR;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        status_d                              = '0;
        status_d[STAT_BUSY]                   = (state_d != ST_IDLE) && (state_d != ST_DONE);
        status_d[STAT_DONE]                   = done_d;
        status_d[STAT_ERR]                    = err_d;
        status_d[STAT_ABORT]                  = abt_d;
        status_d[STAT_STATE_LSB +: 4]         = state_d;
        status_d[STAT_BEATS_LSB +: 16]        = 16'(beats_d);
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            trig_prev_q <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            beats_q     <= '0;
            beat_q      <= '0;
            awlen_q     <= '0;
            awvalid_q   <= 1'b0;
            irq_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            abt_q       <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            trig_prev_q <= DMA_Trigger[TRIG_START];
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            beats_q     <= beats_d;
            beat_q      <= beat_d;
            awlen_q     <= awlen_d;
            awvalid_q   <= awvalid_d;
            irq_q       <= irq_d;
            done_q      <= done_d;
            err_q       <= err_d;
            abt_q       <= abt_d;
            status_q    <= status_d;
        end
    end

endmodule

// File: tb/tb_dma_write_burst_engine.sv
// Directed bench for dma_write_burst_engine: vector table plus corner-case sequences.
module tb_dma_write_burst_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] DMA_Trigger;
    logic [31:0] DMA_BASE_ADDR;
    logic [15:0] DMA_LEN_BEATS;
    logic [31:0] FIFO_RDATA;
    logic        FIFO_EMPTY;
    logic        FIFO_RDEN;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        IRQ;
    logic [31:0] DMA_STATUS;

    always #5 clk = ~clk;

    dma_write_burst_engine dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .DMA_Trigger   (DMA_Trigger),
        .DMA_BASE_ADDR (DMA_BASE_ADDR),
        .DMA_LEN_BEATS (DMA_LEN_BEATS),
        .FIFO_RDATA    (FIFO_RDATA),
        .FIFO_EMPTY    (FIFO_EMPTY),
        .FIFO_RDEN     (FIFO_RDEN),
        .M_AXI_AWADDR  (AWADDR),
        .M_AXI_AWLEN   (AWLEN),
        .M_AXI_AWSIZE  (AWSIZE),
        .M_AXI_AWBURST (AWBURST),
        .M_AXI_AWVALID (AWVALID),
        .M_AXI_AWREADY (AWREADY),
        .M_AXI_WDATA   (WDATA),
        .M_AXI_WSTRB   (WSTRB),
        .M_AXI_WLAST   (WLAST),
        .M_AXI_WVALID  (WVALID),
        .M_AXI_WREADY  (WREADY),
        .M_AXI_BRESP   (BRESP),
        .M_AXI_BVALID  (BVALID),
        .M_AXI_BREADY  (BREADY),
        .IRQ           (IRQ),
        .DMA_STATUS    (DMA_STATUS)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor-owned records
    logic [31:0] aw_addr_log[$];
    logic [7:0]  aw_len_log[$];
    int          wlast_pos[$];
    int          w_count = 0, pop_count = 0, irq_count = 0, irq_long = 0;
    int          proto_err = 0, data_err = 0, b_owed = 0;
    logic [31:0] exp_word = 32'hA500_0000;
    bit          irq_prev = 1'b0, b_fire_s = 1'b0, pop_s = 1'b0;

    // Driver-owned state
    logic [31:0] fifo_word;
    int          b_sent;
    bit          tog;

    // Main-owned modes
    bit empty_force = 1'b0, empty_toggle = 1'b0, wready_rand = 1'b0, err_en = 1'b0;
    int err_burst = 0;

    // Snapshots
    int s_aw, s_w, s_pop, s_irq, s_long, s_perr, s_derr, s_wl;

    typedef struct {
        logic [31:0] base;
        logic [15:0] len;
        bit          toggle;
        bit          wrand;
        bit          err;
        int          awcnt;
        logic [31:0] a0;
        logic [7:0]  l0;
        logic [31:0] a1;
        logic [7:0]  l1;
        int          beats;
        logic [31:0] status;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Sample handshakes mid-cycle; what is seen here is what the next posedge commits.
    always @(negedge clk) begin
        if (rst_n) begin
            if (AWVALID && AWREADY) begin
                aw_addr_log.push_back(AWADDR);
                aw_len_log.push_back(AWLEN);
            end
            if (WVALID && FIFO_EMPTY) proto_err++;
            if (FIFO_RDEN != (WVALID && WREADY)) proto_err++;
            if (WVALID && WREADY) begin
                w_count++;
                if (WDATA !== exp_word) data_err++;
                exp_word++;
                if (WLAST) begin
                    wlast_pos.push_back(w_count);
                    b_owed++;
                end
            end
            if (FIFO_RDEN) pop_count++;
            if (IRQ) begin
                irq_count++;
                if (irq_prev) irq_long++;
            end
            irq_prev = IRQ;
            b_fire_s = BVALID && BREADY;
            pop_s    = FIFO_RDEN;
        end else begin
            irq_prev = 1'b0;
            b_fire_s = 1'b0;
            pop_s    = 1'b0;
        end
    end

    // FIFO model and AXI slave, updated just after each posedge.
    initial begin
        fifo_word  = 32'hA500_0000;
        FIFO_RDATA = fifo_word;
        FIFO_EMPTY = 1'b1;
        AWREADY    = 1'b1;
        WREADY     = 1'b1;
        BVALID     = 1'b0;
        BRESP      = 2'b00;
        b_sent     = 0;
        tog        = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pop_s) fifo_word = fifo_word + 32'd1;
            FIFO_RDATA = fifo_word;
            tog        = ~tog;
            FIFO_EMPTY = empty_force | (empty_toggle & tog);
            WREADY     = wready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (BVALID && b_fire_s) begin
                BVALID = 1'b0;
                b_sent++;
            end
            if (!BVALID && (b_owed > b_sent)) begin
                BVALID = 1'b1;
                BRESP  = (err_en && (b_sent == err_burst)) ? 2'b10 : 2'b00;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic snap();
        s_aw   = aw_addr_log.size();
        s_w    = w_count;
        s_pop  = pop_count;
        s_irq  = irq_count;
        s_long = irq_long;
        s_perr = proto_err;
        s_derr = data_err;
        s_wl   = wlast_pos.size();
    endtask

    task automatic start_pulse(input logic [31:0] base, input logic [15:0] len);
        @(posedge clk);
        #2;
        DMA_BASE_ADDR  = base;
        DMA_LEN_BEATS  = len;
        DMA_Trigger[0] = 1'b1;
        @(posedge clk);
        #2;
        DMA_Trigger[0] = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        int n;
        n = 0;
        while ((irq_count == s_irq) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_irq_seen"}, 64'(irq_count != s_irq), 64'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_aw(input string name);
        int n;
        n = 0;
        while ((aw_addr_log.size() == s_aw) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_aw_seen"}, 64'(aw_addr_log.size() - s_aw), 64'd1);
    endtask

    initial begin
        vecs[0] = '{32'h1000_0000, 16'd32, 1'b0, 1'b0, 1'b0, 2, 32'h1000_0000, 8'd15, 32'h1000_0040, 8'd15, 32, 32'h0020_0002};
        vecs[1] = '{32'h1000_0FF8, 16'd6,  1'b0, 1'b0, 1'b0, 2, 32'h1000_0FF8, 8'd1,  32'h1000_1000, 8'd3,  6,  32'h0006_0002};
        vecs[2] = '{32'h2000_0100, 16'd20, 1'b1, 1'b1, 1'b0, 2, 32'h2000_0100, 8'd15, 32'h2000_0140, 8'd3,  20, 32'h0014_0002};
        vecs[3] = '{32'h1000_0000, 16'd32, 1'b0, 1'b0, 1'b1, 1, 32'h1000_0000, 8'd15, 32'h0,         8'd0,  16, 32'h0010_0004};
        vecs[4] = '{32'h4000_0000, 16'd0,  1'b0, 1'b0, 1'b0, 0, 32'h0,         8'd0,  32'h0,         8'd0,  0,  32'h0000_0002};
        vecs[5] = '{32'h3000_0FC3, 16'd20, 1'b0, 1'b0, 1'b0, 2, 32'h3000_0FC0, 8'd15, 32'h3000_1000, 8'd3,  20, 32'h0014_0002};
        vecs[6] = '{32'h0000_0FFC, 16'd3,  1'b0, 1'b0, 1'b0, 2, 32'h0000_0FFC, 8'd0,  32'h0000_1000, 8'd1,  3,  32'h0003_0002};
        vecs[7] = '{32'hFFFF_FFC0, 16'd20, 1'b0, 1'b0, 1'b0, 2, 32'hFFFF_FFC0, 8'd15, 32'h0000_0000, 8'd3,  20, 32'h0014_0002};

        rst_n         = 1'b0;
        DMA_Trigger   = 32'h0;
        DMA_BASE_ADDR = 32'h0;
        DMA_LEN_BEATS = 16'h0;
        repeat (3) @(negedge clk);

        check("rst_awvalid", 64'(AWVALID), 64'd0);
        check("rst_wvalid",  64'(WVALID),  64'd0);
        check("rst_bready",  64'(BREADY),  64'd0);
        check("rst_rden",    64'(FIFO_RDEN), 64'd0);
        check("rst_irq",     64'(IRQ),     64'd0);
        check("rst_status",  64'(DMA_STATUS), 64'd0);
        check("awsize",      64'(AWSIZE),  64'd2);
        check("awburst",     64'(AWBURST), 64'd1);
        check("wstrb",       64'(WSTRB),   64'hF);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            empty_toggle = vecs[i].toggle;
            wready_rand  = vecs[i].wrand;
            err_en       = vecs[i].err;
            err_burst    = b_sent;
            snap();
            start_pulse(vecs[i].base, vecs[i].len);
            wait_irq($sformatf("v%0d", i));
            check($sformatf("v%0d_awcnt", i), 64'(aw_addr_log.size() - s_aw), 64'(vecs[i].awcnt));
            if ((vecs[i].awcnt > 0) && (aw_addr_log.size() > s_aw)) begin
                check($sformatf("v%0d_aw0_addr", i), 64'(aw_addr_log[s_aw]), 64'(vecs[i].a0));
                check($sformatf("v%0d_aw0_len", i),  64'(aw_len_log[s_aw]),  64'(vecs[i].l0));
                check($sformatf("v%0d_wlast0", i), 64'((wlast_pos.size() > s_wl) ? wlast_pos[s_wl] - s_w : -1),
                      64'(int'(vecs[i].l0) + 1));
            end
            if ((vecs[i].awcnt > 1) && (aw_addr_log.size() > s_aw + 1)) begin
                check($sformatf("v%0d_aw1_addr", i), 64'(aw_addr_log[s_aw + 1]), 64'(vecs[i].a1));
                check($sformatf("v%0d_aw1_len", i),  64'(aw_len_log[s_aw + 1]),  64'(vecs[i].l1));
                check($sformatf("v%0d_wlast1", i), 64'((wlast_pos.size() > s_wl + 1) ? wlast_pos[s_wl + 1] - s_w : -1),
                      64'(int'(vecs[i].l0) + int'(vecs[i].l1) + 2));
            end
            check($sformatf("v%0d_wlast_cnt", i), 64'(wlast_pos.size() - s_wl), 64'(vecs[i].awcnt));
            check($sformatf("v%0d_beats", i),   64'(w_count - s_w),     64'(vecs[i].beats));
            check($sformatf("v%0d_pops", i),    64'(pop_count - s_pop), 64'(vecs[i].beats));
            check($sformatf("v%0d_irq_cnt", i), 64'(irq_count - s_irq), 64'd1);
            check($sformatf("v%0d_irq_len", i), 64'(irq_long - s_long), 64'd0);
            check($sformatf("v%0d_proto", i),   64'(proto_err - s_perr), 64'd0);
            check($sformatf("v%0d_data", i),    64'(data_err - s_derr), 64'd0);
            check($sformatf("v%0d_status", i),  64'(DMA_STATUS), 64'(vecs[i].status));
            empty_toggle = 1'b0;
            wready_rand  = 1'b0;
            err_en       = 1'b0;
        end

        // len 0: IRQ exactly in the cycle after the edge is registered
        snap();
        @(posedge clk);
        #2;
        DMA_LEN_BEATS  = 16'd0;
        DMA_Trigger[0] = 1'b1;
        @(negedge clk);
        check("len0_irq_before", 64'(IRQ), 64'd0);
        @(posedge clk);
        #2;
        DMA_Trigger[0] = 1'b0;
        @(negedge clk);
        check("len0_irq_pulse", 64'(IRQ), 64'd1);
        @(negedge clk);
        check("len0_irq_after", 64'(IRQ), 64'd0);
        check("len0_no_aw", 64'(aw_addr_log.size() - s_aw), 64'd0);
        check("len0_status", 64'(DMA_STATUS), 64'h0000_0002);

        // Start held high for 100 cycles runs one transfer only
        snap();
        @(posedge clk);
        #2;
        DMA_BASE_ADDR  = 32'h5000_0000;
        DMA_LEN_BEATS  = 16'd16;
        DMA_Trigger[0] = 1'b1;
        repeat (100) @(negedge clk);
        DMA_Trigger[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("hold_irq_cnt", 64'(irq_count - s_irq), 64'd1);
        check("hold_awcnt", 64'(aw_addr_log.size() - s_aw), 64'd1);
        check("hold_beats", 64'(w_count - s_w), 64'd16);
        check("hold_status", 64'(DMA_STATUS), 64'h0010_0002);

        // Abort during DATA: burst finishes, nothing further issued
        snap();
        empty_force = 1'b1;
        start_pulse(32'h1000_0000, 16'd32);
        wait_aw("abort");
        repeat (3) @(negedge clk);
        DMA_Trigger[1] = 1'b1;
        empty_force    = 1'b0;
        wait_irq("abort");
        check("abort_awcnt", 64'(aw_addr_log.size() - s_aw), 64'd1);
        check("abort_beats", 64'(w_count - s_w), 64'd16);
        check("abort_irq_cnt", 64'(irq_count - s_irq), 64'd1);
        check("abort_status", 64'(DMA_STATUS), 64'h0010_0008);
        DMA_Trigger[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-DATA, then a clean len-16 transfer
        snap();
        empty_force = 1'b1;
        start_pulse(32'h1000_0000, 16'd32);
        wait_aw("rstmid");
        empty_force = 1'b0;
        @(posedge clk);
        #2;
        check("rstmid_pre_wvalid", 64'(WVALID), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_awvalid", 64'(AWVALID), 64'd0);
        check("rstmid_wvalid",  64'(WVALID),  64'd0);
        check("rstmid_rden",    64'(FIFO_RDEN), 64'd0);
        check("rstmid_bready",  64'(BREADY),  64'd0);
        check("rstmid_irq",     64'(IRQ),     64'd0);
        check("rstmid_status",  64'(DMA_STATUS), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        snap();
        start_pulse(32'h6000_0000, 16'd16);
        wait_irq("post_rst");
        check("post_rst_awcnt", 64'(aw_addr_log.size() - s_aw), 64'd1);
        if (aw_addr_log.size() > s_aw) begin
            check("post_rst_aw_addr", 64'(aw_addr_log[s_aw]), 64'h6000_0000);
            check("post_rst_aw_len",  64'(aw_len_log[s_aw]),  64'd15);
        end
        check("post_rst_beats", 64'(w_count - s_w), 64'd16);
        check("post_rst_data", 64'(data_err - s_derr), 64'd0);
        check("post_rst_status", 64'(DMA_STATUS), 64'h0010_0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
